cache_plru_tree: RTL and testbench

Parametrised tree pseudo-LRU replacement engine for the set-associative caches. It is a generalisation of the fixed 4-way L1 pLRU. The block holds one (WAYS-1)-bit binary tree per set. Trees are updated on every hit or fill ("touch"), and the block returns a registered victim way on request. Invalid ways are filled first, locked ways are steered around, and a sequenced init sweep clears all trees. It sits beside the tag array in the cache controller.

---
 rtl/cache_plru_tree_if.sv | 34 +++
 rtl/cache_plru_tree.sv | 159 +++++++++++++++
 tb/tb_cache_plru_tree.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_plru_tree_if.sv
// Request/response bundle between the cache controller and the tree pLRU engine.
// The controller drives the master side; the engine implements the slave side.
interface cache_plru_tree_if #(
  parameter int unsigned WAYS = 8,
  parameter int unsigned SETS = 128
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned SET_W = $clog2(SETS);

  logic             init;
  logic             busy;
  logic             touch_valid;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             vict_req;
  logic [SET_W-1:0] vict_set;
  logic [WAYS-1:0]  vict_way_valid;
  logic [WAYS-1:0]  vict_lock;
  logic             vict_valid;
  logic [WAY_W-1:0] vict_way;
  logic             vict_all_locked;

  modport master (
    output init, touch_valid, touch_set, touch_way,
    output vict_req, vict_set, vict_way_valid, vict_lock,
    input  busy, vict_valid, vict_way, vict_all_locked
  );

  modport slave (
    input  init, touch_valid, touch_set, touch_way,
    input  vict_req, vict_set, vict_way_valid, vict_lock,
    output busy, vict_valid, vict_way, vict_all_locked
  );
endinterface

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU replacement engine: one (WAYS-1)-bit heap-ordered tree per set,
// updated on touch, queried for a registered victim, cleared by a one-set-per-cycle sweep.
module cache_plru_tree #(
  parameter int unsigned WAYS = 8,
  parameter int unsigned SETS = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cache_plru_tree_if.slave bus
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned NW    = WAYS - 1;

  typedef enum logic [0:0] {StIdle, StInit} state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             vict_valid_q, vict_valid_d;
  logic [WAY_W-1:0] vict_way_q, vict_way_d;
  logic             vict_al_q, vict_al_d;
  logic [NW-1:0]    tree_q [SETS];
  logic [NW-1:0]    tree_d [SETS];

  logic [NW-1:0]     t_mask, t_val;
  logic [NW-1:0]     vict_tree;
  logic [2*WAYS-2:0] sub_ok;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way, tree_way;

  // Touch: node bits along the root-to-leaf path of touch_way.
  always_comb begin
    int unsigned tw;
    int unsigned node;
    t_mask = '0;
    t_val  = '0;
    tw     = 32'(bus.touch_way);
    node   = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      node   = ((32'd1 << l) - 32'd1) + (tw >> (WAY_W - 32'(l)));
      t_mask = t_mask | (NW'(1) << node);
      if (((tw >> (WAY_W - 32'd1 - 32'(l))) & 32'd1) != 32'd0) begin
        t_val = t_val | (NW'(1) << node);
      end
    end
  end

  // Full-tree heap: leaves are the unlocked ways, internal nodes OR their children.
  always_comb begin
    sub_ok = '0;
    sub_ok[2*WAYS-2:WAYS-1] = ~bus.vict_lock;
    for (int n = int'(WAYS) - 2; n >= 0; n--) begin
      sub_ok[n] = sub_ok[2*n+1] | sub_ok[2*n+2];
    end
  end

  assign vict_tree = tree_q[bus.vict_set];

  always_comb begin
    int unsigned       node;
    logic              pick_hi;
    logic [NW-1:0]     nb;
    logic [2*WAYS-2:0] ok;
    node      = 0;
    pick_hi   = 1'b0;
    nb        = '0;
    ok        = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    // Descending scan so the lowest-index invalid candidate wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!bus.vict_lock[w] && !bus.vict_way_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    for (int l = 0; l < int'(WAY_W); l++) begin
      nb      = vict_tree >> node;
      pick_hi = ~nb[0];
      node    = 2 * node + 1 + {31'b0, pick_hi};
      ok      = sub_ok >> node;
      if (!ok[0]) node = pick_hi ? node - 1 : node + 1;
    end
    tree_way = WAY_W'(node - (WAYS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.init) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      StInit: begin
        if (cnt_q == SET_W'(SETS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StInit);
  end

  always_comb begin
    vict_valid_d = (state_q == StIdle) && bus.vict_req;
    vict_way_d   = vict_way_q;
    vict_al_d    = vict_al_q;
    if (vict_valid_d) begin
      if (!sub_ok[0]) begin
        vict_way_d = '0;
        vict_al_d  = 1'b1;
      end else begin
        vict_way_d = inv_found ? inv_way : tree_way;
        vict_al_d  = 1'b0;
      end
    end
  end

  always_comb begin
    tree_d = tree_q;
    if (state_q == StInit) begin
      tree_d[cnt_q] = '0;
    end else if (bus.touch_valid) begin
      tree_d[bus.touch_set] = (tree_q[bus.touch_set] & ~t_mask) | t_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      vict_valid_q <= 1'b0;
      vict_way_q   <= '0;
      vict_al_q    <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) tree_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      vict_valid_q <= vict_valid_d;
      vict_way_q   <= vict_way_d;
      vict_al_q    <= vict_al_d;
      tree_q       <= tree_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.vict_valid      = vict_valid_q;
  assign bus.vict_way        = vict_way_q;
  assign bus.vict_all_locked = vict_al_q;
endmodule

// File: tb/tb_cache_plru_tree.sv
// Bench for cache_plru_tree (8 ways, 4 sets): vector table plus init/reset sequences,
// with victim results checked through an expected-result queue.
module tb_cache_plru_tree;
  localparam int unsigned WAYS = 8;
  localparam int unsigned SETS = 4;

  typedef struct {
    logic       tv;
    logic [1:0] ts;
    logic [2:0] tw;
    logic       qr;
    logic [1:0] qs;
    logic [7:0] qv;
    logic [7:0] ql;
    logic [2:0] ew;
    logic       eal;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   busy_cnt;
  vec_t vecs[$];
  vec_t idle_v;
  logic [3:0] sb[$];
  logic [3:0] exp_r;
  logic [2:0] hold_w;
  logic       hold_al;

  cache_plru_tree_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  cache_plru_tree #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t vq(input logic [1:0] s, input logic [7:0] v, input logic [7:0] l,
                              input logic [2:0] ew, input logic eal);
    vec_t r;
    r = '{default: '0};
    r.qr = 1'b1; r.qs = s; r.qv = v; r.ql = l; r.ew = ew; r.eal = eal;
    return r;
  endfunction

  function automatic vec_t vt(input logic [1:0] s, input logic [2:0] w);
    vec_t r;
    r = '{default: '0};
    r.tv = 1'b1; r.ts = s; r.tw = w;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.init           = 1'b0;
    bus.touch_valid    = v.tv;
    bus.touch_set      = v.ts;
    bus.touch_way      = v.tw;
    bus.vict_req       = v.qr;
    bus.vict_set       = v.qs;
    bus.vict_way_valid = v.qv;
    bus.vict_lock      = v.ql;
  endtask

  task automatic cyc(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    if (v.qr) sb.push_back({v.ew, v.eal});
  endtask

  // Result monitor: pops the expected queue on every vict_valid, checks hold otherwise.
  initial begin
    hold_w  = '0;
    hold_al = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_w  = '0;
        hold_al = 1'b0;
      end else if (bus.vict_valid) begin
        check("spurious_vict_valid", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_r = sb.pop_front();
          check("vict_way", int'(bus.vict_way), int'(exp_r[3:1]));
          check("vict_all_locked", int'(bus.vict_all_locked), int'(exp_r[0]));
          hold_w  = exp_r[3:1];
          hold_al = exp_r[0];
        end
      end else begin
        check("hold_way", int'(bus.vict_way), int'(hold_w));
        check("hold_all_locked", int'(bus.vict_all_locked), int'(hold_al));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    idle_v = '{default: '0};
    drive(idle_v);

    vecs.push_back(vq(2'd2, 8'hFF, 8'h00, 3'd7, 1'b0));
    for (int w = 0; w < 8; w++) vecs.push_back(vt(2'd0, 3'(w)));
    vecs.push_back(vq(2'd0, 8'hFF, 8'h00, 3'd0, 1'b0));
    vecs.push_back(vq(2'd1, 8'hFF, 8'h00, 3'd7, 1'b0));
    vecs.push_back(vq(2'd2, 8'hDF, 8'h00, 3'd5, 1'b0));
    vecs.push_back(vq(2'd2, 8'hDF, 8'h20, 3'd7, 1'b0));
    vecs.push_back(vq(2'd0, 8'hDF, 8'h20, 3'd0, 1'b0));
    vecs.push_back(vq(2'd2, 8'hFF, 8'h80, 3'd6, 1'b0));
    vecs.push_back(vq(2'd2, 8'hFF, 8'hF0, 3'd3, 1'b0));
    vecs.push_back(vq(2'd2, 8'hFF, 8'hFF, 3'd0, 1'b1));
    vecs.push_back(vq(2'd0, 8'hFF, 8'h01, 3'd1, 1'b0));
    vecs.push_back(vq(2'd0, 8'hFF, 8'h0F, 3'd4, 1'b0));
    vecs.push_back(vq(2'd2, 8'h00, 8'h03, 3'd2, 1'b0));
    v = vq(2'd1, 8'hFF, 8'h00, 3'd7, 1'b0);
    v.tv = 1'b1; v.ts = 2'd1; v.tw = 3'd7;
    vecs.push_back(v);
    vecs.push_back(vq(2'd1, 8'hFF, 8'h00, 3'd3, 1'b0));
    vecs.push_back(vt(2'd1, 3'd3));
    vecs.push_back(vq(2'd1, 8'hFF, 8'h00, 3'd5, 1'b0));
    vecs.push_back(vq(2'd1, 8'h7F, 8'h00, 3'd7, 1'b0));
    vecs.push_back(vq(2'd1, 8'h00, 8'h00, 3'd0, 1'b0));
    vecs.push_back(idle_v);
    vecs.push_back(idle_v);

    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_vict_valid", int'(bus.vict_valid), 0);
    check("rst_vict_way", int'(bus.vict_way), 0);
    check("rst_all_locked", int'(bus.vict_all_locked), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) cyc(vecs[i]);

    // Init sweep with touches, queries and init held active throughout it.
    cyc(vt(2'd3, 3'd7));
    cyc(vq(2'd3, 8'hFF, 8'h00, 3'd3, 1'b0));
    @(posedge clk);
    #1;
    drive(idle_v);
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.touch_valid    = 1'b1;
    bus.touch_set      = 2'd3;
    bus.touch_way      = 3'd3;
    bus.vict_req       = 1'b1;
    bus.vict_set       = 2'd3;
    bus.vict_way_valid = 8'hFF;
    bus.vict_lock      = 8'h00;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    check("busy_len", busy_cnt, 4);
    @(posedge clk);
    #1;
    drive(idle_v);
    @(negedge clk);
    check("busy_end", int'(bus.busy), 0);
    cyc(vq(2'd3, 8'hFF, 8'h00, 3'd7, 1'b0));
    cyc(idle_v);

    // Reset in the second busy cycle aborts the sweep and clears every tree.
    cyc(vt(2'd2, 3'd7));
    cyc(vt(2'd3, 3'd7));
    @(posedge clk);
    #1;
    drive(idle_v);
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    @(negedge clk);
    check("busy_start", int'(bus.busy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("busy_abort", int'(bus.busy), 0);
    check("valid_abort", int'(bus.vict_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("busy_after_rst", int'(bus.busy), 0);
    cyc(vq(2'd3, 8'hFF, 8'h00, 3'd7, 1'b0));
    cyc(vq(2'd2, 8'hFF, 8'h00, 3'd7, 1'b0));
    cyc(idle_v);

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
